// File: rtl/obi_stream_writer.sv
// OBI write initiator: drains a valid/ready word stream into one OBI write per word,
// to a fixed or auto-incrementing address, with outstanding tracking and error flag.
module obi_stream_writer #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic                  incr_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  req_o,
    input  logic                  gnt_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  we_o,
    output logic [3:0]            be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic                  rvalid_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  done_cnt_o,
    output logic                  err_o
);

    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OutW-1:0] MaxOut = OutW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {StIdle, StReq, StStall, StDrain} state_e;

    state_e                state_q, state_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [OutW-1:0]       out_q, out_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic                  incr_q, incr_d;
    logic [CNT_WIDTH-1:0]  done_cnt_q, done_cnt_d;
    logic                  err_q, err_d;
    logic                  en_q;

    logic fire;
    logic accept;
    logic rsp_ok;
    logic load_addr;
    logic unused_rdata;

    assign unused_rdata = ^rdata_i;

    // en_q keeps ready_o low while in reset and for the first edge after release.
    assign req_o      = (state_q == StReq);
    assign fire       = req_o & gnt_i;
    assign ready_o    = en_q & (~hold_valid_q | fire);
    assign accept     = valid_i & ready_o;
    assign rsp_ok     = rvalid_i & (out_q != '0);
    assign addr_o     = cur_addr_q;
    assign wdata_o    = hold_data_q;
    assign we_o       = 1'b1;
    assign be_o       = 4'hF;
    assign busy_o     = (state_q != StIdle) | (out_q != '0);
    assign done_cnt_o = done_cnt_q;
    assign err_o      = err_q;

    always_comb begin
        out_d = out_q;
        if (fire && !rsp_ok) begin
            out_d = out_q + 1'b1;
        end else if (!fire && rsp_ok) begin
            out_d = out_q - 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_addr = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StReq;
                    load_addr = 1'b1;
                end
            end
            StReq: begin
                if (fire) begin
                    if (accept) begin
                        state_d = (out_d == MaxOut) ? StStall : StReq;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StStall: begin
                if (out_d < MaxOut) begin
                    state_d = StReq;
                end
            end
            StDrain: begin
                if (accept) begin
                    state_d = (out_d == MaxOut) ? StStall : StReq;
                end else if (out_d == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = data_i;
        end else if (fire) begin
            hold_valid_d = 1'b0;
        end

        cur_addr_d = cur_addr_q;
        incr_d     = incr_q;
        if (load_addr) begin
            cur_addr_d = base_addr_i;
            incr_d     = incr_en_i;
        end else if (fire && incr_q) begin
            cur_addr_d = cur_addr_q + ADDR_WIDTH'(4);
        end

        done_cnt_d = done_cnt_q + CNT_WIDTH'(rsp_ok);
        err_d      = err_q | (rvalid_i & (out_q == '0));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            out_q        <= '0;
            cur_addr_q   <= '0;
            incr_q       <= 1'b0;
            done_cnt_q   <= '0;
            err_q        <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            out_q        <= out_d;
            cur_addr_q   <= cur_addr_d;
            incr_q       <= incr_d;
            done_cnt_q   <= done_cnt_d;
            err_q        <= err_d;
            en_q         <= 1'b1;
        end
    end

endmodule

// File: tb/tb_obi_stream_writer.sv
// Directed self-checking bench for obi_stream_writer (default parameters, MAX_OUTSTANDING=2).
module tb_obi_stream_writer;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] base_addr_i;
    logic        incr_en_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic        req_o;
    logic        gnt_i;
    logic [31:0] addr_o;
    logic        we_o;
    logic [3:0]  be_o;
    logic [31:0] wdata_o;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic        busy_o;
    logic [15:0] done_cnt_o;
    logic        err_o;

    obi_stream_writer dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .base_addr_i(base_addr_i),
        .incr_en_i  (incr_en_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .req_o      (req_o),
        .gnt_i      (gnt_i),
        .addr_o     (addr_o),
        .we_o       (we_o),
        .be_o       (be_o),
        .wdata_o    (wdata_o),
        .rvalid_i   (rvalid_i),
        .rdata_i    (rdata_i),
        .busy_o     (busy_o),
        .done_cnt_o (done_cnt_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          exp_done = 0;
    bit          auto_rsp = 1'b0;
    logic        acc;
    logic        fire;
    logic [31:0] tx_data [0:7];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];

    // Called just after a negedge; samples before the next posedge, returns at next negedge.
    task automatic tick();
        #2;
        acc  = valid_i & ready_o;
        fire = req_o & gnt_i;
        if (fire) begin
            wr_addr.push_back(addr_o);
            wr_data.push_back(wdata_o);
        end
        @(negedge clk);
        if (auto_rsp) rvalid_i = fire;
    endtask

    task automatic run_stream(input int n, input logic [31:0] base, input logic incr);
        int idx = 0;
        logic [31:0] exp_a;
        wr_addr.delete();
        wr_data.delete();
        base_addr_i = base;
        incr_en_i   = incr;
        gnt_i       = 1'b1;
        auto_rsp    = 1'b1;
        for (int c = 0; c < 60 && !(idx == n && !busy_o); c++) begin
            valid_i = (idx < n);
            data_i  = (idx < n) ? tx_data[idx] : 32'h0;
            tick();
            if (acc) idx++;
        end
        valid_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || idx != n) begin
            $display("FAIL stream_done: busy=%0b accepted=%0d, required busy=0 accepted=%0d",
                     busy_o, idx, n);
            failures++;
        end
        checks++;
        if (wr_addr.size() != n) begin
            $display("FAIL write_count: got %0d required %0d", wr_addr.size(), n);
            failures++;
        end
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            exp_a = incr ? base + 32'(4 * i) : base;
            checks++;
            if (wr_addr[i] !== exp_a || wr_data[i] !== tx_data[i]) begin
                $display("FAIL write[%0d]: addr=%h data=%h required addr=%h data=%h",
                         i, wr_addr[i], wr_data[i], exp_a, tx_data[i]);
                failures++;
            end
        end
        exp_done += n;
        checks++;
        if (done_cnt_o !== 16'(exp_done) || err_o !== 1'b0) begin
            $display("FAIL stream_status: done=%0d err=%0b required done=%0d err=0",
                     done_cnt_o, err_o, exp_done);
            failures++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; base_addr_i = '0; incr_en_i = 1'b0; data_i = '0; valid_i = 1'b0;
        gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({req_o, ready_o, busy_o, err_o, we_o, be_o} !== 9'b0000_1_1111 ||
            addr_o !== 32'h0 || wdata_o !== 32'h0 || done_cnt_o !== 16'h0) begin
            $display("FAIL reset_values: req=%b rdy=%b busy=%b err=%b we=%b be=%h addr=%h wd=%h",
                     req_o, ready_o, busy_o, err_o, we_o, be_o, addr_o, wdata_o);
            failures++;
        end
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({ready_o, req_o, busy_o} !== 3'b100) begin
            $display("FAIL after_reset: ready/req/busy=%b required 100", {ready_o, req_o, busy_o});
            failures++;
        end
        @(negedge clk);
    endtask

    task automatic test_fixed_addr();
        tx_data[0] = 32'hA; tx_data[1] = 32'hB; tx_data[2] = 32'hC; tx_data[3] = 32'hD;
        run_stream(4, 32'h2000_0000, 1'b0);
    endtask

    task automatic test_incr_addr();
        tx_data[0] = 32'h11; tx_data[1] = 32'h12; tx_data[2] = 32'h13;
        run_stream(3, 32'h0000_0100, 1'b1);
    endtask

    task automatic test_wrap();
        tx_data[0] = 32'h21; tx_data[1] = 32'h22;
        run_stream(2, 32'hFFFF_FFFC, 1'b1);
    endtask

    task automatic test_grant_stall();
        logic [65:0] got;
        wr_addr.delete();
        wr_data.delete();
        auto_rsp = 1'b1;
        base_addr_i = 32'h300; incr_en_i = 1'b0;
        valid_i = 1'b1; data_i = 32'h55; gnt_i = 1'b0;
        tick();
        valid_i = 1'b0; data_i = 32'h66;
        for (int c = 0; c < 5; c++) begin
            #1;
            got = {req_o, ready_o, addr_o, wdata_o};
            checks++;
            if (got !== {1'b1, 1'b0, 32'h300, 32'h55}) begin
                $display("FAIL gnt_stall[%0d]: req=%b rdy=%b addr=%h wd=%h required 1 0 300 55",
                         c, req_o, ready_o, addr_o, wdata_o);
                failures++;
            end
            tick();
        end
        checks++;
        if (wr_addr.size() != 0) begin
            $display("FAIL gnt_stall_nowrite: got %0d writes required 0", wr_addr.size());
            failures++;
        end
        gnt_i = 1'b1;
        tick();
        gnt_i = 1'b0;
        for (int c = 0; c < 10 && busy_o; c++) tick();
        exp_done += 1;
        checks++;
        if (wr_addr.size() != 1 || busy_o !== 1'b0 || done_cnt_o !== 16'(exp_done)) begin
            $display("FAIL gnt_stall_single: writes=%0d busy=%b done=%0d required 1 0 %0d",
                     wr_addr.size(), busy_o, done_cnt_o, exp_done);
            failures++;
        end else begin
            checks++;
            if (wr_addr[0] !== 32'h300 || wr_data[0] !== 32'h55) begin
                $display("FAIL gnt_stall_write: addr=%h data=%h required 300 55",
                         wr_addr[0], wr_data[0]);
                failures++;
            end
        end
    endtask

    task automatic test_outstanding();
        wr_addr.delete();
        wr_data.delete();
        auto_rsp = 1'b0; rvalid_i = 1'b0;
        base_addr_i = 32'h400; incr_en_i = 1'b0; gnt_i = 1'b1;
        valid_i = 1'b1;
        data_i = 32'h71; tick();
        data_i = 32'h72; tick();
        data_i = 32'h73; tick();
        valid_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({req_o, ready_o, busy_o} !== 3'b001) begin
                $display("FAIL max_out_stall[%0d]: req/rdy/busy=%b required 001",
                         c, {req_o, ready_o, busy_o});
                failures++;
            end
            tick();
        end
        checks++;
        if (wr_addr.size() != 2) begin
            $display("FAIL max_out_grants: got %0d required 2", wr_addr.size());
            failures++;
        end
        rvalid_i = 1'b1;
        tick();
        #1;
        checks++;
        if (req_o !== 1'b1 || wdata_o !== 32'h73) begin
            $display("FAIL third_req: req=%b wd=%h required 1 73", req_o, wdata_o);
            failures++;
        end
        tick();  // grant and response in the same cycle
        rvalid_i = 1'b0;
        #1;
        checks++;
        if ({req_o, busy_o} !== 2'b01) begin
            $display("FAIL gnt_rvalid_same: req/busy=%b required 01", {req_o, busy_o});
            failures++;
        end
        tick();
        rvalid_i = 1'b1;
        tick();
        rvalid_i = 1'b0;
        #1;
        exp_done += 3;
        checks++;
        if (busy_o !== 1'b0 || done_cnt_o !== 16'(exp_done) || err_o !== 1'b0) begin
            $display("FAIL out_drain: busy=%b done=%0d err=%b required 0 %0d 0",
                     busy_o, done_cnt_o, err_o, exp_done);
            failures++;
        end
        checks++;
        if (wr_addr.size() != 3 || wr_data[wr_data.size()-1] !== 32'h73) begin
            $display("FAIL out_writes: count=%0d required 3 ending in 73", wr_addr.size());
            failures++;
        end
    endtask

    task automatic test_error();
        auto_rsp = 1'b0; gnt_i = 1'b0; valid_i = 1'b0;
        rvalid_i = 1'b1;
        tick();
        rvalid_i = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b1 || done_cnt_o !== 16'(exp_done)) begin
            $display("FAIL err_set: err=%b done=%0d required 1 %0d", err_o, done_cnt_o, exp_done);
            failures++;
        end
        tick();
        tick();
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            $display("FAIL err_sticky: err=%b busy=%b required 1 0", err_o, busy_o);
            failures++;
        end
    endtask

    task automatic test_reset_midop();
        auto_rsp = 1'b0; rvalid_i = 1'b0;
        base_addr_i = 32'h500; incr_en_i = 1'b1;
        valid_i = 1'b1; data_i = 32'h81; gnt_i = 1'b0;
        tick();
        gnt_i = 1'b1; data_i = 32'h82;
        tick();
        valid_i = 1'b0; gnt_i = 1'b0;
        #1;
        checks++;
        if ({req_o, busy_o} !== 2'b11 || addr_o !== 32'h504 || wdata_o !== 32'h82) begin
            $display("FAIL midop_setup: req/busy=%b addr=%h wd=%h required 11 504 82",
                     {req_o, busy_o}, addr_o, wdata_o);
            failures++;
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({req_o, ready_o, busy_o, err_o, we_o, be_o} !== 9'b0000_1_1111 ||
            addr_o !== 32'h0 || wdata_o !== 32'h0 || done_cnt_o !== 16'h0) begin
            $display("FAIL midop_reset: req=%b rdy=%b busy=%b err=%b addr=%h wd=%h done=%0d",
                     req_o, ready_o, busy_o, err_o, addr_o, wdata_o, done_cnt_o);
            failures++;
        end
        exp_done = 0;
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        rvalid_i = 1'b1;
        tick();
        rvalid_i = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b1 || done_cnt_o !== 16'h0 || busy_o !== 1'b0) begin
            $display("FAIL late_rvalid: err=%b done=%0d busy=%b required 1 0 0",
                     err_o, done_cnt_o, busy_o);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_fixed_addr();
        test_incr_addr();
        test_wrap();
        test_grant_stall();
        test_outstanding();
        test_error();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obi_stream_writer.md
Name: obi_stream_writer

Overview:
OBI initiator that drains a local valid/ready word stream and turns each word into one OBI write transaction. Its main target is the writer-side OBI port of the FIFO serial-link wrapper, which is a responder; this block is the initiator at the other end of that port. Address is either fixed (FIFO target) or auto-incrementing (memory target). It tracks outstanding transactions, counts completed writes, and flags protocol errors.

Parameters:
DATA_WIDTH, 32, width of stream data and OBI wdata/rdata
ADDR_WIDTH, 32, OBI address width
MAX_OUTSTANDING, 2, max granted-but-not-rvalid writes (1..7)
CNT_WIDTH, 16, width of completed-write counter

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
base_addr_i  input  ADDR_WIDTH  target address; sampled when leaving IDLE
incr_en_i  input  1  1: address += 4 per granted write; 0: fixed address; sampled with base_addr_i
data_i  input  DATA_WIDTH  stream word
valid_i  input  1  stream word valid
ready_o  output  1  stream word accepted when valid_i & ready_o
req_o  output  1  OBI request
gnt_i  input  1  OBI grant
addr_o  output  ADDR_WIDTH  OBI address
we_o  output  1  OBI write enable, constant 1
be_o  output  4  OBI byte enable, constant 4'b1111
wdata_o  output  DATA_WIDTH  OBI write data
rvalid_i  input  1  OBI response valid
rdata_i  input  DATA_WIDTH  ignored
busy_o  output  1  1 when state != IDLE or outstanding != 0
done_cnt_o  output  CNT_WIDTH  number of rvalid responses since reset
err_o  output  1  sticky: rvalid_i seen with outstanding == 0

Behaviour:
- Reset values:
  - all outputs 0 except we_o = 1 and be_o = 4'hF
  - state = IDLE; hold register empty; outstanding = 0; address register = 0
- Hold register (1 entry):
  - loads data_i on valid_i & ready_o
  - ready_o = ~hold_valid | (req_o & gnt_i), which allows back-to-back streaming with one word per granted cycle
- Address capture:
  - on the IDLE→REQ transition, cur_addr <= base_addr_i and incr mode is latched
  - in incr mode, cur_addr += 4 on each req_o & gnt_i, wrapping modulo 2^ADDR_WIDTH
  - addr_o = cur_addr
- FSM:
  - IDLE: hold empty. Stream accept moves to REQ.
  - REQ: req_o = 1; wdata_o = hold data; addr_o is stable.
    - on gnt_i: if a new word is accepted the same cycle, stay in REQ (next address); else go to DRAIN.
  - STALL: hold valid but outstanding == MAX_OUTSTANDING; req_o = 0. Go to REQ when outstanding drops below max.
  - DRAIN: hold empty, outstanding > 0.
    - stream accept → REQ, or STALL if outstanding == max after this cycle's update
    - outstanding == 0 with no accept → IDLE
  - From REQ after gnt, the next state is STALL if the new word is held and outstanding reaches max.
- OBI rules:
  - once req_o rises, req_o, addr_o and wdata_o stay constant until the gnt_i cycle
  - req_o is never asserted while outstanding == MAX_OUTSTANDING
  - req_o and gnt_i are combinationally independent (req_o depends only on registered state)
- Outstanding counter:
  - +1 on req_o & gnt_i; −1 on rvalid_i & outstanding != 0; no change when both occur in the same cycle
  - rvalid_i with outstanding == 0 sets err_o and leaves the counter unchanged
- done_cnt_o:
  - +1 on each valid rvalid_i (outstanding != 0)
  - wraps modulo 2^CNT_WIDTH
- Latency:
  - first stream accept to req_o: 1 cycle
  - with gnt_i tied high and responses arriving 1 cycle after grant: sustains 1 write/cycle when MAX_OUTSTANDING >= 2
- Reset mid-operation:
  - asynchronous; everything returns to reset values immediately
  - any in-flight word or response is dropped; a late rvalid_i after reset sets err_o

Test Plan:
- Fixed address: base_addr_i=0x2000_0000, incr_en_i=0, 4 words 0xA..0xD, gnt_i=1, rvalid_i 1 cycle after grant → 4 writes, all to 0x2000_0000, in order; done_cnt_o=4; busy_o back to 0; err_o=0.
- Incrementing address: base 0x100, incr_en_i=1, 3 words → addr_o sequence 0x100, 0x104, 0x108.
- Wrap-around: base 0xFFFF_FFFC, incr_en_i=1, 2 words → addr_o 0xFFFF_FFFC then 0x0000_0000.
- Grant stall: gnt_i low for 5 cycles during a request → req_o, addr_o and wdata_o held constant; ready_o=0; one write only on grant.
- Outstanding limit: MAX_OUTSTANDING=2, gnt_i=1, rvalid_i withheld → exactly 2 grants, then req_o=0 (STALL). One rvalid_i → 3rd request issued next cycle. Simultaneous gnt and rvalid → counter unchanged.
- Error and reset: rvalid_i pulse when idle → err_o=1 and stays set, done_cnt_o unchanged. Assert rst_ni low while in REQ with outstanding=1 → all outputs at reset values; err_o=0.
